// File: rtl/lz_bit_packer.sv
// lz_bit_packer
//   Packs variable-width LZ symbol codes into fixed-width words, LSB-first
//   (deflate bit order). The last token of a block makes the packer flush its
//   partial word, zero-padded, with a valid-byte count, and then pulse done.
//
// Ports
//   clk         rising-edge clock
//   rst         synchronous reset, active-low
//   tok_valid   token present
//   tok_ready   packer can accept a token this cycle
//   tok_data    code bits, bit 0 transmitted first
//   tok_len     number of valid bits in tok_data (clamped to tok_width)
//   tok_last    final token of the block
//   word_valid  output word present
//   word_ready  consumer accepts word
//   word_data   packed bits, bit 0 first
//   word_bytes  valid bytes in word_data (full word except on the final word)
//   word_last   final word of the block
//   done        one-cycle pulse after the final word handshake
module lz_bit_packer #(
  parameter int unsigned tok_width  = 16,
  parameter int unsigned len_width  = 5,
  parameter int unsigned word_width = 32,
  parameter int unsigned acc_width  = 64,
  parameter int unsigned cnt_width  = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tok_valid,
  output logic                  tok_ready,
  input  logic [tok_width-1:0]  tok_data,
  input  logic [len_width-1:0]  tok_len,
  input  logic                  tok_last,
  output logic                  word_valid,
  input  logic                  word_ready,
  output logic [word_width-1:0] word_data,
  output logic [2:0]            word_bytes,
  output logic                  word_last,
  output logic                  done
);

  typedef enum logic [1:0] {
    ST_PACK  = 2'd0,
    ST_FLUSH = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [cnt_width-1:0] WORD_CNT    = cnt_width'(word_width);
  localparam logic [cnt_width-1:0] READY_LIMIT = cnt_width'(acc_width - tok_width);
  localparam logic [len_width-1:0] LEN_MAX     = len_width'(tok_width);
  localparam logic [2:0]           FULL_BYTES  = 3'(word_width / 8);

  state_t                 state_q, state_d;
  logic [acc_width-1:0]   acc_q, acc_d;
  logic [cnt_width-1:0]   cnt_q, cnt_d;

  logic [len_width-1:0]   len_clamped;
  logic [tok_width-1:0]   tok_masked;
  logic [acc_width-1:0]   acc_base;
  logic [cnt_width-1:0]   cnt_base;
  logic [cnt_width-1:0]   cnt_round;
  logic                   last_word;
  logic                   tok_accept;
  logic                   word_hs;

  // Input token conditioning: clamp the length and zero the unused bits.
  always_comb begin
    len_clamped = tok_len;
    if (tok_len > LEN_MAX) begin
      len_clamped = LEN_MAX;
    end
    tok_masked = '0;
    for (int unsigned i = 0; i < tok_width; i++) begin
      tok_masked[i] = tok_data[i] && (i < 32'(len_clamped));
    end
  end

  // Output side, derived from registered state only (plus reset gating so
  // nothing handshakes while the block is being reset).
  always_comb begin
    cnt_round  = cnt_q + cnt_width'(7);
    last_word  = (state_q == ST_FLUSH) && (cnt_q <= WORD_CNT);

    tok_ready  = 1'b0;
    word_valid = 1'b0;
    word_last  = 1'b0;
    word_bytes = '0;
    done       = 1'b0;
    word_data  = acc_q[word_width-1:0];

    unique case (state_q)
      ST_PACK: begin
        tok_ready  = rst && (cnt_q <= READY_LIMIT);
        word_valid = rst && (cnt_q >= WORD_CNT);
        word_bytes = (cnt_q >= WORD_CNT) ? FULL_BYTES : 3'd0;
      end
      ST_FLUSH: begin
        word_valid = rst;
        word_last  = last_word;
        // Final word reports ceil(cnt/8); an empty flush reports zero bytes.
        word_bytes = last_word ? 3'(cnt_round >> 3) : FULL_BYTES;
      end
      ST_DONE: begin
        done = 1'b1;
      end
      default: begin
        done = 1'b0;
      end
    endcase

    tok_accept = tok_valid && tok_ready;
    word_hs    = word_valid && word_ready;
  end

  // Accumulator update. A word handshake and a token accept in the same cycle
  // compose: the shift-out happens first, so the new token lands at the
  // already-reduced bit count.
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    acc_base = acc_q;
    cnt_base = cnt_q;

    if (word_hs) begin
      acc_base = acc_q >> word_width;
      cnt_base = (cnt_q >= WORD_CNT) ? (cnt_q - WORD_CNT) : '0;
    end

    acc_d = acc_base;
    cnt_d = cnt_base;

    if (tok_accept) begin
      acc_d = acc_base | (acc_width'(tok_masked) << cnt_base);
      cnt_d = cnt_base + cnt_width'(len_clamped);
    end

    unique case (state_q)
      ST_PACK: begin
        if (tok_accept && tok_last) begin
          state_d = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        if (word_hs && last_word) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_PACK;
        acc_d   = '0;
        cnt_d   = '0;
      end
      default: begin
        state_d = ST_PACK;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_PACK;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
